pe_fusion_ctrl: RTL and testbench

- Configuration and sequencing controller for one BitFusion fusion-unit PE (16 bitbricks, shift stage, adder tree).
- Accepts a job descriptor: operand precision and signedness per side, plus the number of operand beats to accumulate.
- Drives the PE's 64-bit shift-control bus and per-group sign bits, and gates the operand stream with a valid/ready handshake.
- Owns the 20-bit accumulator fed back to the PE as previous_sum, and returns the final sum through a valid/ready result port.

---
 rtl/pe_fusion_ctrl.sv | 123 ++++++++++++
 tb/tb_pe_fusion_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fusion_ctrl.sv
// BitFusion fusion-unit PE controller: derives per-bitbrick shift/sign config from a
// job descriptor, gates operand beats and owns the 20-bit accumulator fed back to the PE.

module pe_fusion_brick_cfg (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic [1:0] i_mask_x,
    input  logic [1:0] i_mask_y,
    output logic [3:0] o_field
);
    // Masks are (pieces-1), so (a & mask) == a mod pieces for the power-of-two piece counts.
    assign o_field = {1'b0, i_a & i_mask_x, 1'b0} + {1'b0, i_b & i_mask_y, 1'b0};
endmodule

module pe_fusion_ctrl #(
    parameter int LEN_W  = 16,
    parameter int PE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_prec_x,
    input  logic [1:0]       cfg_prec_y,
    input  logic             cfg_signed_x,
    input  logic             cfg_signed_y,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [63:0]      signal,
    output logic [3:0]       sign_x,
    output logic [3:0]       sign_y,
    input  logic [19:0]      PE_sum,
    output logic [19:0]      previous_sum,
    output logic [19:0]      result,
    output logic             result_valid,
    input  logic             result_ready
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_len, r_cnt;
    logic [19:0]        r_acc;
    logic [63:0]        r_signal;
    logic [3:0]         r_sign_x, r_sign_y;
    logic [PE_LAT-1:0]  r_vld_pipe, w_vld_nxt;
    logic               w_cfg_acc, w_beat, w_last;
    logic [1:0]         w_mask_x, w_mask_y;
    logic [15:0][3:0]   w_field;
    logic [3:0]         w_sgn_x, w_sgn_y;

    assign w_mask_x = (cfg_prec_x == 2'd0) ? 2'd0 : (cfg_prec_x == 2'd1) ? 2'd1 : 2'd3;
    assign w_mask_y = (cfg_prec_y == 2'd0) ? 2'd0 : (cfg_prec_y == 2'd1) ? 2'd1 : 2'd3;

    for (genvar g = 0; g < 16; g++) begin : g_brick
        pe_fusion_brick_cfg u_brick (
            .i_a      (2'(g / 4)),
            .i_b      (2'(g % 4)),
            .i_mask_x (w_mask_x),
            .i_mask_y (w_mask_y),
            .o_field  (w_field[g])
        );
    end

    // The top piece of each operand carries the sign.
    for (genvar g = 0; g < 4; g++) begin : g_sign
        assign w_sgn_x[g] = cfg_signed_x & ((2'(g) & w_mask_x) == w_mask_x);
        assign w_sgn_y[g] = cfg_signed_y & ((2'(g) & w_mask_y) == w_mask_y);
    end

    assign cfg_ready    = (r_state == S_IDLE);
    assign op_ready     = (r_state == S_RUN);
    assign result_valid = (r_state == S_DONE);
    assign w_cfg_acc    = cfg_valid & cfg_ready;
    assign w_beat       = op_valid & op_ready;
    assign w_last       = w_beat & (r_cnt == r_len - 1'b1);
    assign w_vld_nxt    = PE_LAT'({r_vld_pipe, w_beat});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cfg_acc) w_state_nxt = (cfg_len != '0) ? S_RUN : S_DONE;
            S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_vld_nxt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_signal   <= '0;
            r_sign_x   <= '0;
            r_sign_y   <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vld_pipe <= w_vld_nxt;
            if (w_cfg_acc) begin
                r_len    <= cfg_len;
                r_cnt    <= '0;
                r_acc    <= '0;
                r_signal <= w_field;
                r_sign_x <= w_sgn_x;
                r_sign_y <= w_sgn_y;
            end else begin
                if (w_beat) r_cnt <= r_cnt + 1'b1;
                // Only the tap of an accepted beat is a real PE result; bubbles are ignored.
                if (r_vld_pipe[PE_LAT-1]) r_acc <= PE_sum;
            end
        end
    end

    assign signal       = r_signal;
    assign sign_x       = r_sign_x;
    assign sign_y       = r_sign_y;
    assign previous_sum = r_acc;
    assign result       = r_acc;
endmodule

// File: tb/tb_pe_fusion_ctrl.sv
// Randomized scoreboard bench for pe_fusion_ctrl with a PE stub adding a delayed
// per-beat contribution to previous_sum.

module tb_pe_fusion_ctrl;
    localparam int LEN_W = 16;
    localparam int LAT   = 1;

    logic clk, reset, cfg_valid, cfg_ready, cfg_signed_x, cfg_signed_y;
    logic [1:0] cfg_prec_x, cfg_prec_y;
    logic [LEN_W-1:0] cfg_len;
    logic op_valid, op_ready, result_valid, result_ready;
    logic [63:0] signal;
    logic [3:0] sign_x, sign_y;
    logic [19:0] PE_sum, previous_sum, result, op_contrib;
    logic [19:0] stub_q [LAT];

    typedef struct {
        logic [19:0] res;
        logic [63:0] sig;
        logic [3:0]  sx;
        logic [3:0]  sy;
    } exp_t;

    exp_t sb[$];
    int nvec = 0, nerr = 0, jobs_done = 0;

    pe_fusion_ctrl #(.LEN_W(LEN_W), .PE_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_prec_x(cfg_prec_x), .cfg_prec_y(cfg_prec_y),
        .cfg_signed_x(cfg_signed_x), .cfg_signed_y(cfg_signed_y), .cfg_len(cfg_len),
        .op_valid(op_valid), .op_ready(op_ready), .signal(signal),
        .sign_x(sign_x), .sign_y(sign_y), .PE_sum(PE_sum), .previous_sum(previous_sum),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE stub: accepted beats contribute op_contrib after LAT cycles; bubbles inject junk.
    always @(posedge clk) begin
        stub_q[0] <= (op_valid && op_ready) ? op_contrib : 20'($urandom);
        for (int k = 1; k < LAT; k++) stub_q[k] <= stub_q[k-1];
    end
    assign PE_sum = previous_sum + stub_q[LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int pieces(input int p);
        return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    endfunction

    function automatic logic [63:0] exp_sig(input int px, input int py);
        logic [63:0] r;
        int nx, ny;
        nx = pieces(px);
        ny = pieces(py);
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'(2 * ((i / 4) % nx) + 2 * ((i % 4) % ny));
        return r;
    endfunction

    function automatic logic [3:0] exp_sgn(input int p, input bit s);
        logic [3:0] r;
        int n;
        n = pieces(p);
        for (int a = 0; a < 4; a++) r[a] = s && ((a % n) == n - 1);
        return r;
    endfunction

    // Monitor: pops on every result handshake and checks that a stalled result holds.
    initial begin
        exp_t e;
        bit hold_pend;
        logic [19:0] hold_val;
        hold_pend = 0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (reset) hold_pend = 0;
            else if (result_valid) begin
                if (hold_pend) chk("hold_result", result, hold_val);
                if (result_ready) begin
                    if (sb.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_result: got %h expected none", result);
                    end else begin
                        e = sb.pop_front();
                        chk("result", result, e.res);
                        chk("signal", signal, e.sig);
                        chk("sign_x", sign_x, e.sx);
                        chk("sign_y", sign_y, e.sy);
                    end
                    jobs_done++;
                    hold_pend = 0;
                end else begin
                    hold_pend = 1;
                    hold_val = result;
                end
            end else if (hold_pend) begin
                chk("hold_valid", result_valid, 1);
                hold_pend = 0;
            end
        end
    end

    initial begin
        result_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 result_ready = ($urandom_range(2) == 0);
        end
    end

    task automatic check_reset_outputs();
        chk("rst_signal", signal, 0);
        chk("rst_signs", {sign_x, sign_y}, 0);
        chk("rst_prev_sum", previous_sum, 0);
        chk("rst_result", result, 0);
        chk("rst_hs", {cfg_ready, op_ready, result_valid}, 3'b100);
    endtask

    task automatic run_job(input int px, input int py, input bit sx, input bit sy, input int len,
                           input bit fixed, input logic [19:0] cval, input int abort_at);
        logic [19:0] c[$];
        logic [19:0] v;
        exp_t e;
        int idx, start, cyc;
        bit acc;
        e.res = '0;
        for (int i = 0; i < len; i++) begin
            v = fixed ? cval : 20'($urandom);
            c.push_back(v);
            e.res = e.res + v;
        end
        e.sig = exp_sig(px, py);
        e.sx = exp_sgn(px, sx);
        e.sy = exp_sgn(py, sy);
        start = jobs_done;
        cfg_valid = 1'b1;
        cfg_prec_x = 2'(px);
        cfg_prec_y = 2'(py);
        cfg_signed_x = sx;
        cfg_signed_y = sy;
        cfg_len = LEN_W'(len);
        cyc = 0;
        do begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk);
            #1 cyc++;
        end while (!acc && cyc < 100);
        // Junk descriptor while busy must be ignored.
        cfg_valid = 1'b0;
        cfg_prec_x = 2'($urandom);
        cfg_prec_y = 2'($urandom);
        cfg_signed_x = 1'($urandom);
        cfg_signed_y = 1'($urandom);
        cfg_len = LEN_W'($urandom);
        if (!acc) begin
            chk("cfg_timeout", 0, 1);
            return;
        end
        if (abort_at < 0) sb.push_back(e);
        if (len == 0) chk("len0_valid", result_valid, 1);
        idx = 0;
        cyc = 0;
        while (jobs_done == start && cyc < 2000) begin
            op_valid = ($urandom_range(3) != 0);
            op_contrib = (idx < len) ? c[idx] : 20'($urandom);
            @(negedge clk);
            acc = op_valid && op_ready;
            @(posedge clk);
            #1 cyc++;
            if (acc) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                op_valid = 1'b0;
                reset = 1'b1;
                #1 check_reset_outputs();
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
        end
        op_valid = 1'b0;
        if (jobs_done == start) chk("job_timeout", 0, 1);
        chk("beats_accepted", idx, len);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_prec_x = '0;
        cfg_prec_y = '0;
        cfg_signed_x = 1'b0;
        cfg_signed_y = 1'b0;
        cfg_len = '0;
        op_valid = 1'b0;
        op_contrib = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_job(2, 2, 1, 1, 1, 0, 20'h0, -1);
        run_job(1, 1, 1, 1, 3, 1, 20'd5, -1);
        run_job(0, 0, 0, 0, 4, 0, 20'h0, -1);
        run_job(3, 1, 1, 0, 0, 0, 20'h0, -1);
        run_job(2, 0, 0, 1, 2, 1, 20'h80000, -1);
        run_job(2, 2, 1, 1, 5, 0, 20'h0, 2);
        run_job(1, 2, 0, 1, 1, 0, 20'h0, -1);
        for (int j = 0; j < 25; j++)
            run_job($urandom_range(3), $urandom_range(3), 1'($urandom), 1'($urandom),
                    $urandom_range(12), 0, 20'h0, -1);
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
